load_scoreboard_hazard_unit: RTL and testbench
==============================================

Name: load_scoreboard_hazard_unit

Overview:
- Parametrised successor to the single-load-use stall check.
- Keeps a per-register scoreboard of loads in flight, so memory latency can vary (multi-cycle, handshake-completed) and several loads can be outstanding at once.
- Sits in the ID stage: gates ID->EX issue, stalls IF/ID on RAW dependencies and outstanding-load overflow, and kills ID issue on a taken branch from EX.

Parameters:
- REG_ADDR_W, 5: register index width; scoreboard depth is 2**REG_ADDR_W; register 0 is never tracked.
- MAX_OUTSTANDING, 4: maximum loads in flight, from 1 to 2**REG_ADDR_W-1.
- WB_BYPASS, 1: when 1, a completion arriving in the same cycle satisfies a dependent read with no stall; when 0, the stall is held one more cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1  in  REG_ADDR_W  ID source 1 index
- id_rs2  in  REG_ADDR_W  ID source 2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_W  ID destination index
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  redirect from EX this cycle
- wb_load_done  in  1  a load's data returns this cycle
- wb_rd  in  REG_ADDR_W  destination of the returning load
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- id_issue  out  1  ID instruction advances to EX this cycle
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  loads in flight
- busy_vec  out  2**REG_ADDR_W  scoreboard; bit 0 is always 0
- sb_error  out  1  sticky protocol error
- stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high on rst. On reset, busy_vec=0, outstanding=0, sb_error=0, stall_cycles=0. With state cleared, stall=0 and flush=0.
- Reset mid-operation discards all in-flight tracking. Any late wb_load_done after reset falls under the error rule below.
- Combinational outputs (from registered state and current inputs):
  - clr_hit(r) = wb_load_done & (wb_rd==r) & WB_BYPASS.
  - raw = id_valid & [ (id_rs1_used & rs1!=0 & busy[rs1] & ~clr_hit(rs1)) | same for rs2 ].
  - full = id_valid & id_mem_read & (outstanding==MAX_OUTSTANDING) & ~wb_load_done.
  - stall = (raw | full) & ~ex_branch_taken.
  - flush = ex_branch_taken.
  - id_issue = id_valid & ~stall & ~flush.
- Sequential update (each clk edge, rst=0):
  - set = id_issue & id_mem_read & (id_rd!=0). Sets busy[id_rd]. A load to x0 is not counted.
  - clr = wb_load_done & (outstanding!=0). Clears busy[wb_rd].
  - Same register set and cleared in one cycle: set wins, so busy stays 1 (WAW: the new load owns it).
  - outstanding += set - clr. Simultaneous set and clear leaves it unchanged. It never exceeds MAX_OUTSTANDING and never goes negative.
  - wb_load_done while outstanding==0, or with busy[wb_rd]==0: sb_error<=1 (sticky until rst), scoreboard unchanged.
  - Two loads to the same rd both in flight: the first completion clears busy. Completions are in order, so the younger load's result arrives later; the bench must not issue that pattern without the external pipeline ordering it.
- Latency: a load issued in cycle N shows busy in cycle N+1. A dependent instruction in ID in cycle N+1 stalls until the completion cycle (WB_BYPASS=1) or the cycle after it (WB_BYPASS=0).
- Branch priority: flush overrides stall in the same cycle. No issue happens and scoreboard state is kept; loads already in EX/MEM still complete.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with stall=1, saturates at 32'hFFFFFFFF, and clears on rst.
- Not defined: stall_cycles is tied to 0 and no counter flops are inferred.

Test Plan:
- Basic load-use: issue load x5; next cycle an add with rs1=5 used; wb_load_done at cycle +3 -> stall=1 for 3 cycles (WB_BYPASS=1) or 4 cycles (WB_BYPASS=0). busy_vec[5] falls after completion; outstanding goes 1->0.
- Unused operand: busy x7; ID has rs2=7 with id_rs2_used=0 -> stall=0, id_issue=1.
- x0 handling: load to rd=0 -> busy_vec unchanged, outstanding=0. Load to x3 then ID reads rs1=0 -> no stall.
- Full: MAX_OUTSTANDING=4, issue loads x1..x4, fifth load in ID -> stall=1. Same cycle as a wb_load_done -> fifth issues, outstanding stays 4.
- Collisions: completion of x9 while issuing a new load x9 -> busy_vec[9]=1, outstanding unchanged. ex_branch_taken during a RAW stall -> flush=1, stall=0, id_issue=0.
- Errors and reset: wb_load_done with outstanding=0 -> sb_error=1 and held. rst mid-flight with 3 loads -> next cycle busy_vec=0, outstanding=0, sb_error=0, stall_cycles=0 (macro on).

Source files
------------

// File: rtl/load_scoreboard_hazard_unit.sv
// ID-stage load scoreboard: tracks in-flight load destinations, stalls on RAW and overflow, flushes on taken branch.
// Optional stall-cycle performance counter is built when HAZARD_PERF_CNT_EN is defined.
module load_scoreboard_hazard_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [REG_ADDR_W-1:0]                id_rs1,
  input  logic [REG_ADDR_W-1:0]                id_rs2,
  input  logic                                 id_rs1_used,
  input  logic                                 id_rs2_used,
  input  logic [REG_ADDR_W-1:0]                id_rd,
  input  logic                                 id_mem_read,
  input  logic                                 ex_branch_taken,
  input  logic                                 wb_load_done,
  input  logic [REG_ADDR_W-1:0]                wb_rd,
  output logic                                 stall,
  output logic                                 flush,
  output logic                                 id_issue,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [2**REG_ADDR_W-1:0]             busy_vec,
  output logic                                 sb_error,
  output logic [31:0]                          stall_cycles
);

  localparam int NREG  = 2**REG_ADDR_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic BYPASS = (WB_BYPASS != 0);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             error_q;

  logic clr_hit_rs1, clr_hit_rs2;
  logic raw_rs1, raw_rs2, raw, full;
  logic set, clr_ok, err_ev;

  // A completing load only hides its own hazard when bypass is enabled.
  always_comb begin
    clr_hit_rs1 = wb_load_done & (wb_rd == id_rs1) & BYPASS;
    clr_hit_rs2 = wb_load_done & (wb_rd == id_rs2) & BYPASS;
    raw_rs1     = id_rs1_used & (id_rs1 != '0) & busy_q[id_rs1] & ~clr_hit_rs1;
    raw_rs2     = id_rs2_used & (id_rs2 != '0) & busy_q[id_rs2] & ~clr_hit_rs2;
    raw         = id_valid & (raw_rs1 | raw_rs2);
    full        = id_valid & id_mem_read & (outstanding_q == MAX_CNT) & ~wb_load_done;
    flush       = ex_branch_taken;
    stall       = (raw | full) & ~ex_branch_taken;
    id_issue    = id_valid & ~stall & ~flush;
  end

  // Completions for an empty or non-busy entry are protocol errors and leave state alone.
  always_comb begin
    set    = id_issue & id_mem_read & (id_rd != '0);
    clr_ok = wb_load_done & (outstanding_q != '0) & busy_q[wb_rd];
    err_ev = wb_load_done & ((outstanding_q == '0) | ~busy_q[wb_rd]);
  end

  // Set after clear so a new load to the completing register keeps ownership.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[wb_rd] = 1'b0;
    if (set)    busy_d[id_rd] = 1'b1;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (set && !clr_ok && (outstanding_q != MAX_CNT))
      outstanding_d = outstanding_q + CNT_W'(1);
    else if (clr_ok && !set)
      outstanding_d = outstanding_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      if (err_ev) error_q <= 1'b1;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign sb_error    = error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

  a_out_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding_q <= MAX_CNT);
  a_flush_excl: assert property (@(posedge clk) disable iff (rst)
    flush |-> (!stall && !id_issue));

endmodule

// File: tb/tb_load_scoreboard_hazard_unit.sv
// Scoreboard bench: directed vectors push per-cycle expectations; a monitor pops and compares at negedge.
module tb_load_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_mem_read = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic        ex_branch_taken = 1'b0, wb_load_done = 1'b0;

  logic        stall, flush, id_issue, sb_error;
  logic [2:0]  outstanding;
  logic [31:0] busy_vec, stall_cycles;
  logic        stall_nb, flush_nb, id_issue_nb, sb_error_nb;
  logic [2:0]  outstanding_nb;
  logic [31:0] busy_vec_nb, stall_cycles_nb;

  always #5 clk = ~clk;

  load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .WB_BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .wb_load_done(wb_load_done), .wb_rd(wb_rd), .stall(stall), .flush(flush),
    .id_issue(id_issue), .outstanding(outstanding), .busy_vec(busy_vec),
    .sb_error(sb_error), .stall_cycles(stall_cycles));

  load_scoreboard_hazard_unit #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .WB_BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .wb_load_done(wb_load_done), .wb_rd(wb_rd), .stall(stall_nb), .flush(flush_nb),
    .id_issue(id_issue_nb), .outstanding(outstanding_nb), .busy_vec(busy_vec_nb),
    .sb_error(sb_error_nb), .stall_cycles(stall_cycles_nb));

  typedef struct {
    string       name;
    logic        chk;
    logic        stall, stall_nb, flush, issue, err;
    logic [31:0] outs, busy, perf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   perf  = 0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: combinational outputs and state are presented every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp(e.name, "stall",       {31'b0, stall},        {31'b0, e.stall});
          cmp(e.name, "stall_nb",    {31'b0, stall_nb},     {31'b0, e.stall_nb});
          cmp(e.name, "flush",       {31'b0, flush},        {31'b0, e.flush});
          cmp(e.name, "id_issue",    {31'b0, id_issue},     {31'b0, e.issue});
          cmp(e.name, "outstanding", {29'b0, outstanding},  e.outs);
          cmp(e.name, "busy_vec",    busy_vec,              e.busy);
          cmp(e.name, "sb_error",    {31'b0, sb_error},     {31'b0, e.err});
          cmp(e.name, "stall_cycles", stall_cycles,         e.perf);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; id_rd = '0; id_mem_read = 1'b0; ex_branch_taken = 1'b0;
    wb_load_done = 1'b0; wb_rd = '0;
  endtask

  task automatic chk(input string nm, input logic s, input logic snb, input logic f,
                     input logic iss, input int o, input logic [31:0] b, input logic er);
    exp_t e;
    e.name = nm; e.chk = 1'b1; e.stall = s; e.stall_nb = snb; e.flush = f; e.issue = iss;
    e.outs = o; e.busy = b; e.err = er;
`ifdef HAZARD_PERF_CNT_EN
    e.perf = perf;
`else
    e.perf = 32'd0;
`endif
    exp_q.push_back(e);
    if (s) perf++;
  endtask

  task automatic rst_cyc();
    exp_t e;
    rst = 1'b1;
    e.name = "reset"; e.chk = 1'b0; e.stall = 0; e.stall_nb = 0; e.flush = 0; e.issue = 0;
    e.err = 0; e.outs = 0; e.busy = 0; e.perf = 0;
    exp_q.push_back(e);
    perf = 0;
  endtask

  task automatic ld(input logic [4:0] rd);
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = rd;
  endtask

  task automatic use1(input logic [4:0] rs);
    id_valid = 1'b1; id_rs1 = rs; id_rs1_used = 1'b1; id_rd = 5'd6;
  endtask

  task automatic done(input logic [4:0] rd);
    wb_load_done = 1'b1; wb_rd = rd;
  endtask

  initial begin
    nxt(); rst_cyc();
    nxt(); rst_cyc();
    nxt();                  chk("reset_state", 0, 0, 0, 0, 0, 32'h0, 0);
    // load-use with three-cycle wait before completion
    nxt(); ld(5);           chk("ld_x5",       0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); use1(5);         chk("use_wait1",   1, 1, 0, 0, 1, 32'h20, 0);
    nxt(); use1(5);         chk("use_wait2",   1, 1, 0, 0, 1, 32'h20, 0);
    nxt(); use1(5);         chk("use_wait3",   1, 1, 0, 0, 1, 32'h20, 0);
    nxt(); use1(5); done(5); chk("use_done",   0, 1, 0, 1, 1, 32'h20, 0);
    nxt(); use1(5);         chk("use_after",   0, 0, 0, 1, 0, 32'h0, 0);
    // unused operand
    nxt(); ld(7);           chk("ld_x7",       0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); use1(1); id_rs2 = 5'd7; id_rs2_used = 1'b0;
                            chk("rs2_unused",  0, 0, 0, 1, 1, 32'h80, 0);
    nxt(); done(7);         chk("x7_done",     0, 0, 0, 0, 1, 32'h80, 0);
    // x0 handling
    nxt(); ld(0);           chk("ld_x0",       0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); ld(3);           chk("ld_x3",       0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); use1(0); id_rs2_used = 1'b1;
                            chk("rs1_x0",      0, 0, 0, 1, 1, 32'h8, 0);
    nxt(); done(3);         chk("x3_done",     0, 0, 0, 0, 1, 32'h8, 0);
    // outstanding limit
    nxt(); ld(1);           chk("ld_x1",       0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); ld(2);           chk("ld_x2",       0, 0, 0, 1, 1, 32'h2, 0);
    nxt(); ld(3);           chk("ld_x3b",      0, 0, 0, 1, 2, 32'h6, 0);
    nxt(); ld(4);           chk("ld_x4",       0, 0, 0, 1, 3, 32'he, 0);
    nxt(); ld(10);          chk("full_stall",  1, 1, 0, 0, 4, 32'h1e, 0);
    nxt(); ld(10); done(1); chk("full_done",   0, 0, 0, 1, 4, 32'h1e, 0);
    nxt(); done(2);         chk("full_kept",   0, 0, 0, 0, 4, 32'h41c, 0);
    // same-register set/clear collision
    nxt(); ld(9); done(3);  chk("ld_x9",       0, 0, 0, 1, 3, 32'h418, 0);
    nxt(); ld(9); done(9);  chk("x9_collide",  0, 0, 0, 1, 3, 32'h610, 0);
    // branch during RAW
    nxt(); use1(9); ex_branch_taken = 1'b1;
                            chk("raw_branch",  0, 0, 1, 0, 3, 32'h610, 0);
    nxt(); use1(9);         chk("raw_stall",   1, 1, 0, 0, 3, 32'h610, 0);
    nxt(); done(4);         chk("drain_x4",    0, 0, 0, 0, 3, 32'h610, 0);
    nxt(); done(10);        chk("drain_x10",   0, 0, 0, 0, 2, 32'h600, 0);
    nxt(); done(9);         chk("drain_x9",    0, 0, 0, 0, 1, 32'h200, 0);
    // protocol error
    nxt(); done(6);         chk("err_empty",   0, 0, 0, 0, 0, 32'h0, 0);
    nxt();                  chk("err_sticky",  0, 0, 0, 0, 0, 32'h0, 1);
    // reset mid-flight
    nxt(); ld(12);          chk("ld_x12",      0, 0, 0, 1, 0, 32'h0, 1);
    nxt(); ld(13);          chk("ld_x13",      0, 0, 0, 1, 1, 32'h1000, 1);
    nxt(); ld(14);          chk("ld_x14",      0, 0, 0, 1, 2, 32'h3000, 1);
    nxt(); use1(12);        chk("pre_reset",   1, 1, 0, 0, 3, 32'h7000, 1);
    nxt(); use1(12); rst_cyc();
    nxt(); use1(12);        chk("post_reset",  0, 0, 0, 1, 0, 32'h0, 0);
    nxt(); done(13);        chk("late_done",   0, 0, 0, 0, 0, 32'h0, 0);
    nxt();                  chk("late_err",    0, 0, 0, 0, 0, 32'h0, 1);
    nxt();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
